// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared FSM state type and geometry constants for the burst memory responder
package burst_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} burst_state_t;
   localparam int BEATS    = 4;
   localparam int BEAT_W   = 64;
   localparam int LINE_OFF = 5;
endpackage

// File: rtl/burst_mem_if.sv
// burst_mem_if: 4-beat 64-bit line burst port between an initiator and a memory responder
interface burst_mem_if;
   import burst_mem_pkg::*;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [BEAT_W-1:0] mem_wdata;
   logic              mem_resp;
   logic [BEAT_W-1:0] mem_rdata;
   logic              err;
   modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_resp, mem_rdata, err);
   modport slave  (input mem_read, mem_write, mem_addr, mem_wdata, output mem_resp, mem_rdata, err);
endinterface

// File: rtl/burst_mem_array.sv
// burst_mem_array: word store with one synchronous write port and one registered read port
module burst_mem_array
   import burst_mem_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [BEAT_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [BEAT_W-1:0] rdata
);
   // No reset on the array or its read register so it maps onto block RAM
   logic [BEAT_W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-burst memory responder with programmable latency before four 64-bit beats
module burst_mem_responder
   import burst_mem_pkg::*;
#(
   parameter int LINES   = 256,
   parameter int LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst,
   burst_mem_if.slave bus
);
   localparam int IDX_W  = $clog2(LINES);
   localparam int BEAT_B = $clog2(BEATS);
   localparam int AW     = IDX_W + BEAT_B;
   burst_state_t      state, state_n;
   logic [7:0]        cnt, cnt_n;
   logic [BEAT_B-1:0] beat, beat_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic              rd, rd_n, err_q, err_n, resp, resp_n, req;
   logic              we;
   logic [AW-1:0]     waddr, raddr;
   logic [BEAT_W-1:0] q;
   logic              unused_addr;
   assign req         = bus.mem_read | bus.mem_write;
   assign unused_addr = ^{bus.mem_addr[31:LINE_OFF+IDX_W], bus.mem_addr[LINE_OFF-1:0]};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         beat  <= '0;
         idx   <= '0;
         rd    <= 1'b0;
         err_q <= 1'b0;
         resp  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         beat  <= beat_n;
         idx   <= idx_n;
         rd    <= rd_n;
         err_q <= err_n;
         resp  <= resp_n;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      beat_n  = beat;
      idx_n   = idx;
      rd_n    = rd;
      err_n   = err_q;
      case (state)
         IDLE: if (req) begin
            state_n = WAIT;
            cnt_n   = 8'(LATENCY);
            rd_n    = bus.mem_read;
            idx_n   = bus.mem_addr[LINE_OFF +: IDX_W];
            err_n   = err_q | (bus.mem_read & bus.mem_write);
         end
         WAIT: begin
            cnt_n = cnt - 8'd1;
            if (!req) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == 8'd1) begin
               state_n = BURST;
               beat_n  = '0;
            end
         end
         BURST: begin
            beat_n  = beat + 1'b1;
            state_n = (beat == BEAT_B'(BEATS - 1)) ? DONE : BURST;
         end
         DONE: state_n = req ? DONE : IDLE;
         default: state_n = IDLE;
      endcase
      resp_n = (state_n == BURST);
   end
   // Read address runs one beat ahead so the registered array output lines up with resp
   assign we    = resp & ~rd;
   assign waddr = {idx, beat};
   assign raddr = resp ? {idx, BEAT_B'(beat + 1'b1)} : {idx, {BEAT_B{1'b0}}};
   burst_mem_array #(.AW(AW)) u_array (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(bus.mem_wdata),
      .raddr(raddr),
      .rdata(q)
   );
   assign bus.mem_resp  = resp;
   assign bus.mem_rdata = (resp & rd) ? q : '0;
   assign bus.err       = err_q;
endmodule
